fetch_unit: RTL and testbench

Instruction fetch front-end that sits directly upstream of the decode stage of the 5-stage pipelined CPU and replaces the combinational instruction fetch path. It issues in-order requests to a latency-bearing instruction memory over a valid/ready handshake and buffers responses in a small prefetch queue. It presents one instruction per cycle to the IF/ID register with a valid/ready handshake. It accepts a redirect from the EX stage and discards stale in-flight responses after a taken branch or jump.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared CPU constants and types. Holds the data word width,
//               the canonical NOP encoding and the prefetch queue entry
//               layout used by the fetch front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] i_addr);
        return {i_addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous clear. Read data is taken
//               straight from the storage array, so a pushed word becomes
//               visible at the head one clock after the push.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pop only real data; a push into a full queue is allowed when a pop frees a slot.
    always_comb begin
        w_do_pop  = i_pop && !o_empty;
        w_do_push = i_push && (!o_full || w_do_pop);
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array: data words need no reset, only the pointers qualify them.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; clear wins over any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front-end. Issues in-order word fetches to
//               a latency-bearing instruction memory, buffers responses in a
//               prefetch queue and hands one instruction per cycle to decode.
//               A redirect from EX flushes the queue and arranges for the
//               responses still in flight to be discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc_plus_4
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     c_depth = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] c_four  = 32'd4;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;
    logic [CW:0]     w_credit_used;
    logic            w_accept;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic            w_pop;
    logic [CW-1:0]   w_accept_ext;
    logic [CW-1:0]   w_rsp_ext;
    logic [XLEN-1:0] w_redirect_pc;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Request credit covers both queued entries and responses still owed by memory.
    always_comb begin
        w_credit_used  = {1'b0, w_count} + {1'b0, r_inflight};
        imem_req_valid = rst && !redirect_valid && (w_credit_used < c_depth);
        w_accept       = imem_req_valid && imem_req_ready;
        w_rsp_drop     = imem_rsp_valid && !redirect_valid && (r_drop != '0);
        w_rsp_keep     = imem_rsp_valid && !redirect_valid && (r_drop == '0);
        w_pop          = if_valid && if_ready && !redirect_valid;
        w_accept_ext   = {{(CW-1){1'b0}}, w_accept};
        w_rsp_ext      = {{(CW-1){1'b0}}, imem_rsp_valid};
        w_redirect_pc  = align_word(redirect_pc);
        w_push_entry   = '{pc: r_rsp_pc, insn: imem_rsp_data};
    end

    assign imem_req_addr = r_fetch_pc;

    // Fetch/response PCs and the in-flight and discard counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            // Every response still owed after this cycle belongs to the old stream.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_inflight <= r_inflight - w_rsp_ext;
            r_drop     <= r_inflight - w_rsp_ext;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + c_four;
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + c_four;
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - CW'(1);
            end
            r_inflight <= r_inflight + w_accept_ext - w_rsp_ext;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_prefetch_q (
        .clk     (clk),
        .rst     (rst),
        .i_clear (redirect_valid),
        .i_push  (w_rsp_keep),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Decode-side view of the queue head; idle slots read as a NOP at PC 0.
    always_comb begin
        if_valid       = !w_empty;
        if_pc          = if_valid ? w_head.pc   : '0;
        if_instruction = if_valid ? w_head.insn : NOP_INSN;
        if_pc_plus_4   = if_pc + c_four;
    end

    // Memory must never return more responses than were requested.
    a_rsp_has_inflight: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (r_inflight != '0));

    // The credit scheme guarantees a kept response always finds room.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (w_rsp_keep && w_full) |-> w_pop);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A queue-based reference
//               of the fetch stream and a latency-programmable memory model
//               are checked against the DUT every cycle, with directed
//               scenarios followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] PAT      = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus_4;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_pc_plus_4   (if_pc_plus_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: expected queue contents and outstanding-request bookkeeping.
    fetch_entry_t mq[$];
    int           m_inflight;
    int           m_drop;
    logic [31:0]  m_fpc;
    logic [31:0]  m_rpc;

    // Memory model: accepted addresses with the cycle their response is due.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];
    int    lat = 1;
    int    cyc = 0;

    logic [31:0] popped[$];
    int          acc_total = 0;
    logic        seen_valid;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(string tag, logic [31:0] start, int n);
        chk({tag, "_count"}, 32'(popped.size() >= n), 32'd1);
        for (int i = 0; i < n && i < popped.size(); i++) begin
            chk(tag, popped[i], start + 32'(4 * i));
        end
    endtask

    // One clock: check outputs at the falling edge, advance the reference,
    // then present the memory response for the following cycle.
    task automatic do_cycle();
        logic        exp_rv;
        logic        exp_v;
        logic        acc;
        logic        pop;
        logic [31:0] exp_pc;
        logic [31:0] exp_insn;
        int          rsp;
        @(negedge clk);
        exp_rv   = rst && !redirect_valid && ((mq.size() + m_inflight) < DEPTH);
        exp_v    = rst && (mq.size() > 0);
        exp_pc   = exp_v ? mq[0].pc : 32'h0;
        exp_insn = exp_v ? mq[0].insn : NOP_INSN;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_fpc);
        chk("if_valid", 32'(if_valid), 32'(exp_v));
        chk("if_pc", if_pc, exp_pc);
        chk("if_insn", if_instruction, exp_insn);
        chk("if_pc_plus_4", if_pc_plus_4, exp_pc + 32'd4);
        seen_valid = if_valid;
        acc = exp_rv && imem_req_ready;
        pop = exp_v && if_ready;
        rsp = int'(imem_rsp_valid);
        if (acc) acc_total++;
        if (!rst) begin
            memq.delete();
        end else if (acc) begin
            memq.push_back('{addr: m_fpc, due: cyc + lat});
        end
        if (!rst) begin
            mq.delete();
            m_inflight = 0;
            m_drop     = 0;
            m_fpc      = RESET_PC;
            m_rpc      = RESET_PC;
        end else if (redirect_valid) begin
            mq.delete();
            m_inflight = m_inflight - rsp;
            m_drop     = m_inflight;
            m_fpc      = redirect_pc & ~32'h3;
            m_rpc      = redirect_pc & ~32'h3;
        end else begin
            if (pop) begin
                popped.push_back(if_pc);
                void'(mq.pop_front());
            end
            if (rsp != 0) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    mq.push_back('{pc: m_rpc, insn: m_rpc ^ PAT});
                    m_rpc = m_rpc + 32'd4;
                end
            end
            m_inflight = m_inflight + int'(acc) - rsp;
            if (acc) m_fpc = m_fpc + 32'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].addr ^ PAT;
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, required finish");
        $fatal(1);
    end

    initial begin
        int first_valid;
        int acc_before;
        logic [31:0] start;

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;
        m_inflight     = 0;
        m_drop         = 0;
        m_fpc          = RESET_PC;
        m_rpc          = RESET_PC;

        // Reset, then release with a 1-cycle memory and decode always ready.
        for (int i = 0; i < 3; i++) do_cycle();
        rst = 1'b1;
        popped.delete();
        first_valid = -1;
        for (int k = 0; k < 15; k++) begin
            do_cycle();
            if (first_valid < 0 && seen_valid) first_valid = k;
        end
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        check_seq("reset_stream", RESET_PC, 5);

        // Decode stalls for 10 cycles: requests stop once credit runs out.
        if_ready   = 1'b0;
        acc_before = acc_total;
        for (int k = 0; k < 10; k++) do_cycle();
        chk("stall_accepts_le_depth", 32'((acc_total - acc_before) <= DEPTH), 32'd1);
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        chk("stall_head_valid", 32'(if_valid), 32'd1);
        start = mq[0].pc;
        popped.delete();
        if_ready = 1'b1;
        for (int k = 0; k < 10; k++) do_cycle();
        check_seq("stall_resume", start, 6);

        // 3-cycle memory, then redirect with requests in flight.
        lat = 3;
        for (int k = 0; k < 8; k++) do_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        do_cycle();
        redirect_valid = 1'b0;
        popped.delete();
        for (int k = 0; k < 15; k++) do_cycle();
        check_seq("redir_100", 32'h0000_0100, 6);

        // Redirect coinciding with a response and a pop; target misaligned.
        lat = 1;
        for (int k = 0; k < 8; k++) do_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        do_cycle();
        redirect_valid = 1'b0;
        popped.delete();
        for (int k = 0; k < 10; k++) do_cycle();
        check_seq("redir_203", 32'h0000_0200, 5);

        // Randomized traffic, latency and redirects.
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) lat = int'($urandom_range(1, 3));
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            do_cycle();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;

        // Asynchronous reset in the middle of a busy stream.
        lat      = 2;
        if_ready = 1'b0;
        for (int k = 0; k < 6; k++) do_cycle();
        chk("pre_reset_valid", 32'(if_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_if_valid", 32'(if_valid), 32'd0);
        chk("async_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_if_insn", if_instruction, NOP_INSN);
        chk("async_if_pc", if_pc, 32'h0);
        chk("async_pc_plus_4", if_pc_plus_4, 32'd4);
        for (int k = 0; k < 3; k++) do_cycle();
        rst      = 1'b1;
        if_ready = 1'b1;
        popped.delete();
        for (int k = 0; k < 12; k++) do_cycle();
        check_seq("restart", RESET_PC, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
